alu_cmd_sequencer: RTL and testbench

Sequential front end for the 32-bit combinational ALU: accepts operation commands over a valid/ready handshake and drives the ALU operand and select inputs from registers. It captures the ALU result and returns it, with a zero flag, over a second valid/ready handshake. It supports chaining, where the previous result replaces operand A, so that multi-step computations need no round trip. It sits between a command source (controller or testbench driver) and one ALU instance.

---
 rtl/alu_cmd_sequencer.sv | 97 +++++++++
 tb/tb_alu_cmd_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command/result sequencer in front of a 32-bit combinational ALU.
// Registers the operands, runs a single EXEC cycle and holds the result until the consumer accepts it.
module alu_cmd_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [2:0]       CMD_SEL,
    input  logic [31:0]      CMD_A,
    input  logic [31:0]      CMD_B,
    input  logic             CMD_CHAIN,
    output logic [31:0]      ALU_A,
    output logic [31:0]      ALU_B,
    output logic [2:0]       ALU_SEL,
    input  logic [31:0]      ALU_OUT,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [31:0]      RES_DATA,
    output logic             RES_ZERO,
    output logic [CNT_W-1:0] OP_COUNT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      alu_a_reg, alu_b_reg;
    logic [2:0]       alu_sel_reg;
    logic [31:0]      res_data_reg;
    logic             res_zero_reg;
    logic [CNT_W-1:0] op_count_reg;
    logic             cmd_ready;
    logic             accept;

    // res_data_reg doubles as the chaining source (last captured result).
    always_comb begin
        cmd_ready = 1'b0;
        if (!RST) begin
            case (state_reg)
                IDLE:    cmd_ready = 1'b1;
                DONE:    cmd_ready = RES_READY;
                default: cmd_ready = 1'b0;
            endcase
        end
    end

    assign accept = CMD_VALID && cmd_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    if (RES_READY) state_next = accept ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= IDLE;
            alu_a_reg    <= 32'd0;
            alu_b_reg    <= 32'd0;
            alu_sel_reg  <= 3'b000;
            res_data_reg <= 32'd0;
            res_zero_reg <= 1'b0;
            op_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                alu_a_reg   <= CMD_CHAIN ? res_data_reg : CMD_A;
                alu_b_reg   <= CMD_B;
                alu_sel_reg <= CMD_SEL;
            end
            if (state_reg == EXEC) begin
                res_data_reg <= ALU_OUT;
                res_zero_reg <= (ALU_OUT == 32'd0);
                op_count_reg <= op_count_reg + CNT_W'(1);
            end
        end
    end

    assign CMD_READY = cmd_ready;
    assign ALU_A     = alu_a_reg;
    assign ALU_B     = alu_b_reg;
    assign ALU_SEL   = alu_sel_reg;
    assign RES_VALID = (state_reg == DONE);
    assign RES_DATA  = res_data_reg;
    assign RES_ZERO  = res_zero_reg;
    assign OP_COUNT  = op_count_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU attached.
// Table vectors cover the ALU ops and chaining; hand sequences cover backpressure, reset and counter wrap.
module tb_alu_cmd_sequencer;

    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             CMD_VALID = 1'b0;
    logic             CMD_READY;
    logic [2:0]       CMD_SEL = 3'b000;
    logic [31:0]      CMD_A = 32'd0;
    logic [31:0]      CMD_B = 32'd0;
    logic             CMD_CHAIN = 1'b0;
    logic [31:0]      ALU_A, ALU_B, ALU_OUT;
    logic [2:0]       ALU_SEL;
    logic             RES_VALID;
    logic             RES_READY = 1'b0;
    logic [31:0]      RES_DATA;
    logic             RES_ZERO;
    logic [CNT_W-1:0] OP_COUNT;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    alu_cmd_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_SEL(CMD_SEL), .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_CHAIN(CMD_CHAIN),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_SEL(ALU_SEL), .ALU_OUT(ALU_OUT),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_DATA(RES_DATA), .RES_ZERO(RES_ZERO), .OP_COUNT(OP_COUNT)
    );

    // External combinational ALU the sequencer drives.
    always_comb begin
        case (ALU_SEL)
            3'b000:  ALU_OUT = ALU_A + ALU_B;
            3'b001:  ALU_OUT = ALU_A - ALU_B;
            3'b010:  ALU_OUT = ALU_A & ALU_B;
            3'b011:  ALU_OUT = ALU_A | ALU_B;
            3'b100:  ALU_OUT = ALU_A ^ ALU_B;
            3'b101:  ALU_OUT = ~ALU_A;
            3'b110:  ALU_OUT = ALU_A << 1;
            default: ALU_OUT = ALU_A >> 1;
        endcase
    end

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        chain;
        logic [31:0] exp_alu_a;
        logic [31:0] exp_data;
        logic        exp_zero;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!CMD_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!CMD_READY) check({name, "_ready_timeout"}, 32'(CMD_READY), 32'd1);
    endtask

    // Issue one command, check the EXEC cycle and the result, then accept it.
    task automatic run_vec(input vec_t v, input int idx);
        CMD_SEL = v.sel; CMD_A = v.a; CMD_B = v.b; CMD_CHAIN = v.chain;
        CMD_VALID = 1'b1;
        wait_ready("vec");
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        @(negedge CLK);
        check("exec_res_valid", 32'(RES_VALID), 32'd0);
        @(negedge CLK);
        check("res_valid", 32'(RES_VALID), 32'd1);
        check("alu_a", ALU_A, v.exp_alu_a);
        check("res_data", RES_DATA, v.exp_data);
        check("res_zero", 32'(RES_ZERO), 32'(v.exp_zero));
        check("op_count", 32'(OP_COUNT), 32'(v.exp_cnt));
        $display("vec %0d sel=%b a=%h b=%h chain=%b -> data=%h zero=%b cnt=%0d",
                 idx, v.sel, v.a, v.b, v.chain, RES_DATA, RES_ZERO, OP_COUNT);
        RES_READY = 1'b1;
        @(posedge CLK);
        #1 RES_READY = 1'b0;
        @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(CMD_READY), 32'd0);
        check({tag, "_res_valid"}, 32'(RES_VALID), 32'd0);
        check({tag, "_alu_a"}, ALU_A, 32'd0);
        check({tag, "_alu_b"}, ALU_B, 32'd0);
        check({tag, "_alu_sel"}, 32'(ALU_SEL), 32'd0);
        check({tag, "_res_data"}, RES_DATA, 32'd0);
        check({tag, "_res_zero"}, 32'(RES_ZERO), 32'd0);
        check({tag, "_op_count"}, 32'(OP_COUNT), 32'd0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{3'b000, 32'd5,        32'd3,        1'b0, 32'd5,        32'd8,        1'b0, 4'd1};
        vecs[1] = '{3'b001, 32'd7,        32'd7,        1'b0, 32'd7,        32'd0,        1'b1, 4'd2};
        vecs[2] = '{3'b000, 32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b1, 4'd3};
        vecs[3] = '{3'b000, 32'd10,       32'd5,        1'b0, 32'd10,       32'd15,       1'b0, 4'd4};
        vecs[4] = '{3'b110, 32'hDEAD,     32'd0,        1'b1, 32'd15,       32'd30,       1'b0, 4'd5};
        vecs[5] = '{3'b101, 32'hDEAD,     32'd0,        1'b1, 32'd30,       32'hFFFFFFE1, 1'b0, 4'd6};
        vecs[6] = '{3'b010, 32'hF0F0,     32'hFF00,     1'b0, 32'hF0F0,     32'hF000,     1'b0, 4'd7};
        vecs[7] = '{3'b011, 32'h0F,       32'hF0,       1'b0, 32'h0F,       32'hFF,       1'b0, 4'd8};
        vecs[8] = '{3'b100, 32'hFFFF0000, 32'hFF00FF00, 1'b0, 32'hFFFF0000, 32'h00FFFF00, 1'b0, 4'd9};
        vecs[9] = '{3'b111, 32'h80000001, 32'd0,        1'b0, 32'h80000001, 32'h40000000, 1'b0, 4'd10};

        #1 check_reset_outputs("rst");
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_rst", 32'(CMD_READY), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Backpressure: hold the result while a chained command waits.
        v = '{3'b000, 32'h1230, 32'd4, 1'b0, 32'h1230, 32'h1234, 1'b0, 4'd11};
        CMD_SEL = v.sel; CMD_A = v.a; CMD_B = v.b; CMD_CHAIN = 1'b0; CMD_VALID = 1'b1;
        wait_ready("bp");
        @(posedge CLK);
        #1 CMD_SEL = 3'b100; CMD_A = 32'hDEAD; CMD_B = 32'h1234; CMD_CHAIN = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("bp_res_valid", 32'(RES_VALID), 32'd1);
            check("bp_res_data", RES_DATA, 32'h1234);
            check("bp_res_zero", 32'(RES_ZERO), 32'd0);
            check("bp_cmd_ready", 32'(CMD_READY), 32'd0);
        end
        RES_READY = 1'b1;
        #1 check("bp_ready_follows", 32'(CMD_READY), 32'd1);
        @(posedge CLK);
        #1 CMD_VALID = 1'b0; RES_READY = 1'b0;
        @(negedge CLK);
        check("bp_exec_valid", 32'(RES_VALID), 32'd0);
        check("bp_exec_cmd_ready", 32'(CMD_READY), 32'd0);
        check("bp_chain_alu_a", ALU_A, 32'h1234);
        @(negedge CLK);
        check("bp2_data", RES_DATA, 32'd0);
        check("bp2_zero", 32'(RES_ZERO), 32'd1);
        check("bp2_cnt", 32'(OP_COUNT), 32'd12);
        $display("backpressure: chained xor -> data=%h cnt=%0d", RES_DATA, OP_COUNT);
        RES_READY = 1'b1;
        @(posedge CLK);
        #1 RES_READY = 1'b0;
        @(negedge CLK);

        // Reset during EXEC discards the op; chaining afterwards starts from zero.
        CMD_SEL = 3'b000; CMD_A = 32'd1; CMD_B = 32'd1; CMD_CHAIN = 1'b0; CMD_VALID = 1'b1;
        wait_ready("rst_exec");
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1 check_reset_outputs("mid_exec");
        $display("reset during EXEC: res_valid=%b cnt=%0d", RES_VALID, OP_COUNT);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        run_vec('{3'b000, 32'hDEAD, 32'd3, 1'b1, 32'd0, 32'd3, 1'b0, 4'd1}, 10);

        // Back-to-back with RES_READY high: 2 cycles per op, counter wraps.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        CMD_SEL = 3'b000; CMD_A = 32'd100; CMD_B = 32'd1; CMD_CHAIN = 1'b1;
        CMD_VALID = 1'b1; RES_READY = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge CLK);
            @(posedge CLK);
            @(negedge CLK);
            check("b2b_res_valid", 32'(RES_VALID), 32'd1);
            check("b2b_res_data", RES_DATA, 32'(k));
            if (k >= 15) check("wrap_op_count", 32'(OP_COUNT), 32'(k % 16));
            $display("b2b op %0d -> data=%h cnt=%0d", k, RES_DATA, OP_COUNT);
        end
        CMD_VALID = 1'b0;
        @(posedge CLK);
        #1 RES_READY = 1'b0;
        @(negedge CLK);
        check("idle_after_b2b", 32'(RES_VALID), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
